// File: rtl/pulse_sequencer.sv
// Table-driven pulse sequencer: each entry emits reps pulses spaced ticks+1 enabled cycles apart.
// Optional macro PULSE_SEQUENCER_LOOP_EN repeats the table scan until abort or rst.
module pulse_sequencer #(
   parameter  int N      = 8,
   parameter  int PHASES = 4,
   localparam int PW     = $clog2(PHASES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          ena,
   input  logic          cfg_we,
   input  logic [PW-1:0] cfg_addr,
   input  logic [N-1:0]  cfg_ticks,
   input  logic [7:0]    cfg_reps,
   output logic          pulse,
   output logic [PW-1:0] phase,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, SELECT, RUN, FINISH} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] phase_nxt;
   logic [N-1:0]  tick_cnt, tick_nxt;
   logic [7:0]    rep_cnt, rep_nxt;
   logic          pulse_nxt;
   logic          last;
   logic          any_reps;

   logic [N-1:0]  ticks_tbl [PHASES];
   logic [7:0]    reps_tbl  [PHASES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHASES; i++) begin
            ticks_tbl[i] <= '0;
            reps_tbl[i]  <= '0;
         end
      end else if (cfg_we && state == IDLE) begin
         ticks_tbl[cfg_addr] <= cfg_ticks;
         reps_tbl[cfg_addr]  <= cfg_reps;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= '0;
         tick_cnt <= '0;
         rep_cnt  <= '0;
         pulse    <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         tick_cnt <= tick_nxt;
         rep_cnt  <= rep_nxt;
         pulse    <= pulse_nxt;
      end
   end

   always_comb begin
      any_reps = 1'b0;
      for (int i = 0; i < PHASES; i++) begin
         if (reps_tbl[i] != 8'd0) any_reps = 1'b1;
      end
   end

   assign last = (phase == PW'(PHASES - 1));

   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      tick_nxt  = tick_cnt;
      rep_nxt   = rep_cnt;
      pulse_nxt = 1'b0;
      // abort beats a coinciding match, so the pulse is dropped as well
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         phase_nxt = '0;
         tick_nxt  = '0;
         rep_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = SELECT;
                  phase_nxt = '0;
               end
            end
            SELECT: begin
               if (reps_tbl[phase] == 8'd0) begin
                  if (last) state_nxt = FINISH;
                  else      phase_nxt = phase + PW'(1);
               end else begin
                  tick_nxt  = '0;
                  rep_nxt   = reps_tbl[phase];
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (ena) begin
                  // compare before increment so ticks = all-ones never wraps
                  if (tick_cnt == ticks_tbl[phase]) begin
                     tick_nxt  = '0;
                     rep_nxt   = rep_cnt - 8'd1;
                     pulse_nxt = 1'b1;
                     if (rep_cnt == 8'd1) begin
                        if (last) begin
                           state_nxt = FINISH;
                        end else begin
                           state_nxt = SELECT;
                           phase_nxt = phase + PW'(1);
                        end
                     end
                  end else begin
                     tick_nxt = tick_cnt + N'(1);
                  end
               end
            end
            FINISH: begin
               phase_nxt = '0;
`ifdef PULSE_SEQUENCER_LOOP_EN
               state_nxt = any_reps ? SELECT : IDLE;
`else
               state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == FINISH);

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer; cycle 0 is the cycle in which start is presented.
module tb_pulse_sequencer;
   localparam int N      = 8;
   localparam int PHASES = 4;
   localparam int PW     = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          ena = 1'b1;
   logic          cfg_we = 1'b0;
   logic [PW-1:0] cfg_addr = '0;
   logic [N-1:0]  cfg_ticks = '0;
   logic [7:0]    cfg_reps = '0;
   logic          pulse;
   logic [PW-1:0] phase;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   logic [63:0] pv, dv, bv;
   logic [3:0]  ph;
   int          npulse, first_pulse, done_cyc;

   pulse_sequencer #(.N(N), .PHASES(PHASES)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ena(ena),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_ticks(cfg_ticks), .cfg_reps(cfg_reps),
      .pulse(pulse), .phase(phase), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input int addr, input int t, input int r);
      cfg_we    = 1'b1;
      cfg_addr  = PW'(addr);
      cfg_ticks = N'(t);
      cfg_reps  = 8'(r);
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   // Runs ncyc cycles starting with start=1; ena low in [elo,ehi], abort at acyc,
   // a table write to entry 1 at wcyc, and phase captured at pcyc.
   task automatic run(input int ncyc, input int elo, input int ehi, input int acyc,
                      input int wcyc, input int pcyc);
      pv = '0; dv = '0; bv = '0; ph = '1;
      npulse = 0; first_pulse = -1; done_cyc = -1;
      for (int c = 0; c < ncyc; c++) begin
         start     = (c == 0);
         ena       = !(c >= elo && c <= ehi);
         abort     = (c == acyc);
         cfg_we    = (c == wcyc);
         cfg_addr  = PW'(1);
         cfg_ticks = '0;
         cfg_reps  = 8'd1;
         @(negedge clk);
         if (c < 64) begin
            pv[c] = pulse; dv[c] = done; bv[c] = busy;
         end
         if (c == pcyc) ph = 4'(phase);
         if (pulse) begin
            npulse++;
            if (first_pulse < 0) first_pulse = c;
         end
         if (done && done_cyc < 0) done_cyc = c;
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; ena = 1'b1; cfg_we = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", 64'({pulse, phase, busy, done}), 64'h0);
      @(posedge clk); #1;

`ifndef PULSE_SEQUENCER_LOOP_EN
      // basic: entry0 ticks=2 reps=3
      cfg_write(0, 2, 3);
      run(20, -1, -1, -1, -1, 12);
      chk("basic_pulse", pv, 64'h920);
      chk("basic_done",  dv, 64'h4000);
      chk("basic_busy",  bv, 64'h7FFE);
      chk("basic_phase12", 64'(ph), 64'd2);

      // pause for cycles 3..6 delays every pulse by 4
      run(24, 3, 6, -1, -1, -1);
      chk("pause_pulse", pv, 64'h9200);
      chk("pause_done",  dv, 64'h40000);
      chk("pause_busy",  bv, 64'h7FFFE);

      // abort on the second match
      run(20, -1, -1, 7, -1, -1);
      chk("abort_pulse", pv, 64'h20);
      chk("abort_done",  dv, 64'h0);
      chk("abort_busy",  bv, 64'hFE);

      // table survives abort
      run(20, -1, -1, -1, -1, -1);
      chk("rerun_pulse", pv, 64'h920);
      chk("rerun_done",  dv, 64'h4000);

      // ticks=0 back-to-back pulses, then a later entry
      cfg_write(0, 0, 4);
      cfg_write(2, 1, 2);
      run(20, -1, -1, -1, -1, -1);
      chk("multi_pulse", pv, 64'h1478);
      chk("multi_done",  dv, 64'h2000);
      chk("multi_busy",  bv, 64'h3FFE);

      // maximum period does not wrap
      cfg_write(2, 0, 0);
      cfg_write(0, 255, 1);
      run(270, -1, -1, -1, -1, -1);
      chk("max_first_pulse", 64'(first_pulse), 64'd258);
      chk("max_npulse",      64'(npulse),      64'd1);
      chk("max_done_cyc",    64'(done_cyc),    64'd261);

      // rst mid-RUN clears outputs and table
      run(10, -1, -1, -1, -1, -1);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", 64'({pulse, phase, busy, done}), 64'h0);
      @(posedge clk); #1;

      // empty table, with a write attempted while busy
      run(10, -1, -1, -1, 2, -1);
      chk("empty_pulse", pv, 64'h0);
      chk("empty_done",  dv, 64'h20);
      chk("empty_busy",  bv, 64'h3E);
      run(10, -1, -1, -1, -1, -1);
      chk("busy_write_ignored_pulse", pv, 64'h0);
      chk("busy_write_ignored_done",  dv, 64'h20);
`else
      // looping: one pass is SELECT + 9 RUN + 3 SELECT + FINISH cycles
      cfg_write(0, 2, 3);
      run(50, -1, -1, 45, -1, -1);
      chk("loop_done", dv, 64'h0000_0400_1000_4000);
      chk("loop_pulse_count", 64'(npulse), 64'd9);
      chk("loop_busy_after_abort", bv[49:46], 64'h0);
      chk("loop_busy_before_abort", bv[45:1], {19'h0, 45'h1FFF_FFFF_FFFF});

      run(10, -1, -1, -1, -1, -1);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", 64'({pulse, phase, busy, done}), 64'h0);
      @(posedge clk); #1;

      // empty table ends after one pass even when looping
      run(10, -1, -1, -1, -1, -1);
      chk("empty_pulse", pv, 64'h0);
      chk("empty_done",  dv, 64'h20);
      chk("empty_busy",  bv, 64'h3E);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
